// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle sequencer and its wait timer.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTEXE   = 4'd7,
    S_ALUWB   = 4'd8,
    S_ADDIEXE = 4'd9,
    S_ADDIWB  = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_FAULT   = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MEM    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [1:0] ALUB_RD2    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int WAIT_W = 8;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive stalled cycles of a memory access and flags the cycle
// on which the stall budget is used up.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic active_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_WAIT_MAX - 1);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  // cnt_q holds the stalls already seen, so this cycle is stall number cnt_q+1
  assign timeout_o = active_i && !ready_i && (cnt_q == LAST_WAIT);

  always_comb begin
    cnt_d = '0;
    if (active_i && !ready_i && !timeout_o) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving the datapath
// controls over one shared memory port.
//  state   | meaning              state   | meaning
//  IDLE    | waiting for start    RTEXE   | R-type ALU op
//  FETCH   | instruction read     ALUWB   | R-type writeback
//  DECODE  | dispatch on opcode   ADDIEXE | addi ALU op
//  MEMADR  | lw/sw address        ADDIWB  | addi writeback
//  MEMRD   | data read            BRANCH  | beq compare/update
//  MEMWB   | load writeback       JUMP    | j / jal
//  MEMWR   | data write           FAULT   | trapped until reset
module multicycle_controller
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic             memReq,
  output logic             memWE,
  output logic             iOrD,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             regWrite,
  output logic [1:0]       regDst,
  output logic [1:0]       memToReg,
  output logic             aluSrcA,
  output logic [1:0]       aluSrcB,
  output logic [1:0]       aluOp,
  output logic             busy,
  output logic             fault,
  output logic [CNT_W-1:0] instrCount,
  output logic [3:0]       stateDbg
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;
  logic             in_mem;
  logic             timeout;

  assign in_mem = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

  mc_wait_timer #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX)
  ) u_wait_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .active_i (in_mem),
    .ready_i  (memReady),
    .timeout_o(timeout)
  );

  always_comb begin
    state_d  = state_q;
    retire   = 1'b0;
    memReq   = 1'b0;
    memWE    = 1'b0;
    iOrD     = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = PCSRC_ALU;
    regWrite = 1'b0;
    regDst   = REGDST_RT;
    memToReg = M2R_ALUOUT;
    aluSrcA  = 1'b0;
    aluSrcB  = ALUB_RD2;
    aluOp    = ALUOP_ADD;
    fault    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        memReq  = 1'b1;
        aluSrcB = ALUB_FOUR;
        if (memReady) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        aluSrcB = ALUB_IMM_SH;
        unique case (opcode)
          OP_RTYPE:     state_d = S_RTEXE;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXE;
          OP_J, OP_JAL: state_d = S_JUMP;
          OP_HALT: begin
            state_d = S_IDLE;
            retire  = 1'b1;
          end
          default:      state_d = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = ALUB_IMM;
        state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memReq = 1'b1;
        iOrD   = 1'b1;
        if (memReady)     state_d = S_MEMWB;
        else if (timeout) state_d = S_FAULT;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = M2R_MEM;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        memReq = 1'b1;
        memWE  = 1'b1;
        iOrD   = 1'b1;
        if (memReady) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout) begin
          state_d = S_FAULT;
        end
      end
      S_RTEXE: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        regDst   = REGDST_RD;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_ADDIEXE: begin
        aluSrcA = 1'b1;
        aluSrcB = ALUB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regWrite = 1'b1;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA = 1'b1;
        aluOp   = ALUOP_SUB;
        pcSrc   = PCSRC_ALUOUT;
        pcWrite = zero;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JUMP: begin
        pcSrc   = PCSRC_JUMP;
        pcWrite = 1'b1;
        if (opcode == OP_JAL) begin
          regWrite = 1'b1;
          regDst   = REGDST_RA;
          memToReg = M2R_PC;
        end
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_d = S_FAULT;
    endcase
  end

  assign count_d    = retire ? count_q + CNT_W'(1) : count_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign instrCount = count_q;
  assign stateDbg   = state_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized instruction streams checked cycle by cycle against
// an instruction-level model of the sequencer.
module tb_multicycle_controller;

  localparam int CW    = 8;
  localparam int WMAX  = 4;

  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEMADR = 3, ST_MEMRD = 4;
  localparam int ST_MEMWB = 5, ST_MEMWR = 6, ST_RTEXE = 7, ST_ALUWB = 8, ST_ADDIEXE = 9;
  localparam int ST_ADDIWB = 10, ST_BRANCH = 11, ST_JUMP = 12, ST_FAULT = 13;

  localparam int RTYPE = 'h00, LW = 'h23, SW = 'h2B, BEQ = 'h04;
  localparam int ADDI = 'h08, J = 'h02, JAL = 'h03, HALT = 'h3F, BAD = 'h3E;

  logic          clock = 1'b0;
  logic          reset_n, start, zero, memReady;
  logic [5:0]    opcode;
  logic          memReq, memWE, iOrD, irWrite, pcWrite, regWrite, aluSrcA, busy, fault;
  logic [1:0]    pcSrc, regDst, memToReg, aluSrcB, aluOp;
  logic [CW-1:0] instrCount;
  logic [3:0]    stateDbg;
  logic [18:0]   dut_w;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  multicycle_controller #(.MEM_WAIT_MAX(WMAX), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode), .zero(zero),
    .memReady(memReady), .memReq(memReq), .memWE(memWE), .iOrD(iOrD),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .regWrite(regWrite),
    .regDst(regDst), .memToReg(memToReg), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .busy(busy), .fault(fault), .instrCount(instrCount),
    .stateDbg(stateDbg)
  );

  always #5 clock = ~clock;

  assign dut_w = {memReq, memWE, iOrD, irWrite, pcWrite, pcSrc, regWrite, regDst,
                  memToReg, aluSrcA, aluSrcB, aluOp, busy, fault};

  function automatic logic [18:0] ctl(input int mreq, input int mwe, input int iord,
                                      input int irw, input int pcw, input int pcs,
                                      input int rw, input int rd, input int m2r,
                                      input int asa, input int asb, input int aop,
                                      input int bsy, input int flt);
    return {mreq[0], mwe[0], iord[0], irw[0], pcw[0], pcs[1:0], rw[0], rd[1:0],
            m2r[1:0], asa[0], asb[1:0], aop[1:0], bsy[0], flt[0]};
  endfunction

  function automatic int rb();
    return int'($urandom_range(0, 1));
  endfunction

  function automatic int rnd6();
    return int'($urandom_range(0, 63));
  endfunction

  task automatic retire_one();
    exp_cnt = (exp_cnt + 1) % (1 << CW);
  endtask

  task automatic check_now(input int es, input logic [18:0] ew, input string tag);
    logic [CW-1:0] ec;
    ec = exp_cnt[CW-1:0];
    checks++;
    assert (stateDbg === es[3:0]) else begin
      errors++;
      $error("FAIL %s state: observed %0d expected %0d", tag, stateDbg, es);
    end
    checks++;
    assert (dut_w === ew) else begin
      errors++;
      $error("FAIL %s outputs: observed %b expected %b", tag, dut_w, ew);
    end
    checks++;
    assert (instrCount === ec) else begin
      errors++;
      $error("FAIL %s instrCount: observed %0d expected %0d", tag, instrCount, ec);
    end
  endtask

  // Entered and left 1 time unit after a rising edge; checks at the falling edge.
  task automatic step(input int es, input logic [18:0] ew, input int rdy,
                      input int op, input int z, input string tag);
    memReady = rdy[0];
    opcode   = op[5:0];
    zero     = z[0];
    #4;
    check_now(es, ew, tag);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    check_now(ST_IDLE, '0, "reset");
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic kick();
    start = 1'b1;
    step(ST_IDLE, '0, rb(), rnd6(), rb(), "idle_start");
    start = 1'b0;
  endtask

  task automatic fetch(input int fw);
    int r;
    for (int i = 0; i <= fw; i++) begin
      r = (i == fw) ? 1 : 0;
      step(ST_FETCH, ctl(1, 0, 0, r, r, 0, 0, 0, 0, 0, 1, 0, 1, 0), r, rnd6(), rb(), "fetch");
    end
  endtask

  task automatic instr(input int op, input int z, input int fw, input int mw);
    int r;
    int jl;
    fetch(fw);
    step(ST_DECODE, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0), rb(), op, rb(), "decode");
    case (op)
      RTYPE: begin
        step(ST_RTEXE, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0), rb(), rnd6(), rb(), "rtexe");
        step(ST_ALUWB, ctl(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0), rb(), rnd6(), rb(), "aluwb");
        retire_one();
      end
      LW, SW: begin
        step(ST_MEMADR, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0), rb(), op, rb(), "memadr");
        for (int i = 0; i <= mw; i++) begin
          r = (i == mw) ? 1 : 0;
          if (op == LW)
            step(ST_MEMRD, ctl(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), r, rnd6(), rb(), "memrd");
          else
            step(ST_MEMWR, ctl(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), r, rnd6(), rb(), "memwr");
        end
        if (op == LW)
          step(ST_MEMWB, ctl(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0), rb(), rnd6(), rb(), "memwb");
        retire_one();
      end
      BEQ: begin
        step(ST_BRANCH, ctl(0, 0, 0, 0, z, 1, 0, 0, 0, 1, 0, 1, 1, 0), rb(), rnd6(), z, "beq");
        retire_one();
      end
      ADDI: begin
        step(ST_ADDIEXE, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0), rb(), rnd6(), rb(), "addiexe");
        step(ST_ADDIWB, ctl(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0), rb(), rnd6(), rb(), "addiwb");
        retire_one();
      end
      J, JAL: begin
        jl = (op == JAL) ? 1 : 0;
        step(ST_JUMP, ctl(0, 0, 0, 0, 1, 2, jl, 2 * jl, 2 * jl, 0, 0, 0, 1, 0), rb(), op, rb(), "jump");
        retire_one();
      end
      HALT: begin
        retire_one();
        step(ST_IDLE, '0, rb(), rnd6(), rb(), "halt_idle");
      end
      default: begin
        step(ST_FAULT, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), rb(), rnd6(), rb(), "illegal");
      end
    endcase
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[8];
    int op;
    ops = '{RTYPE, LW, SW, BEQ, ADDI, J, JAL, HALT};
    reset_n  = 1'b0;
    start    = 1'b0;
    zero     = 1'b0;
    memReady = 1'b0;
    opcode   = 6'h00;
    #1;
    check_now(ST_IDLE, '0, "por");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    step(ST_IDLE, '0, 0, 0, 0, "idle_hold");
    kick();
    instr(LW, 0, 0, 3);
    instr(BEQ, 1, 0, 0);
    instr(BEQ, 0, 1, 0);
    instr(JAL, 0, 0, 0);
    instr(J, 1, 0, 0);
    instr(RTYPE, 0, 2, 0);
    instr(ADDI, 1, 0, 0);
    instr(SW, 0, 0, 1);

    // asynchronous reset while a fetch is outstanding
    step(ST_FETCH, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 0, rnd6(), rb(), "fetch_wait");
    memReady = 1'b0;
    do_reset();

    kick();
    instr(BAD, 0, 0, 0);
    start = 1'b1;
    for (int i = 0; i < 3; i++)
      step(ST_FAULT, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), rb(), rnd6(), rb(), "fault_sticky");
    start = 1'b0;
    do_reset();

    kick();
    instr(ADDI, 0, 0, 0);
    instr(HALT, 0, 0, 0);

    kick();
    fetch(0);
    step(ST_DECODE, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1, 0), 0, SW, 0, "decode_sw");
    step(ST_MEMADR, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0), 0, SW, 0, "memadr_sw");
    for (int i = 0; i < WMAX; i++)
      step(ST_MEMWR, ctl(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, rnd6(), rb(), "memwr_stall");
    step(ST_FAULT, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, rnd6(), rb(), "memwr_timeout");
    do_reset();

    kick();
    for (int i = 0; i < WMAX; i++)
      step(ST_FETCH, ctl(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 0, rnd6(), rb(), "fetch_stall");
    step(ST_FAULT, ctl(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, rnd6(), rb(), "fetch_timeout");
    do_reset();

    kick();
    instr(SW, 0, 0, WMAX - 1);
    instr(LW, 0, WMAX - 1, WMAX - 1);

    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 7)];
      instr(op, rb(), int'($urandom_range(0, WMAX - 1)), int'($urandom_range(0, WMAX - 1)));
      if (op == HALT) kick();
    end
    fetch(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer that converts the single-cycle datapath into a FETCH/DECODE/EXECUTE/MEM/WB machine sharing one unified memory port.
- Generates every datapath enable and mux select per state.
- Waits on a memory ready handshake, counts retired instructions, and traps on illegal opcodes and memory timeouts.
- Sits beside the datapath; replaces the purely combinational Control decode.

Parameters:
- MEM_WAIT_MAX, 15: maximum idle cycles in any memory state before entering FAULT (range 1..255).
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  leave IDLE and begin fetching
- opcode  in  6  instr[31:26] from instruction register
- zero  in  1  ALU zero flag
- memReady  in  1  memory completes current access this cycle
- memReq  out  1  memory access request
- memWE  out  1  write (1) / read (0) qualifier for memReq
- iOrD  out  1  memory address: 0 = PC, 1 = ALUOut
- irWrite  out  1  load instruction register
- pcWrite  out  1  load PC
- pcSrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- regWrite  out  1  register file write enable
- regDst  out  2  00 rt, 01 rd, 10 register 31
- memToReg  out  2  00 ALUOut, 01 memory data, 10 PC (already PC+4)
- aluSrcA  out  1  0 = PC, 1 = RD1
- aluSrcB  out  2  00 RD2, 01 constant 4, 10 SignImm, 11 SignImm<<2
- aluOp  out  2  00 add, 01 subtract, 10 decode by funct
- busy  out  1  high outside IDLE and FAULT
- fault  out  1  sticky error flag
- instrCount  out  CNT_W  retired-instruction count
- stateDbg  out  4  current state encoding

Behaviour:
- Reset (asynchronous, any cycle including mid-access):
  - State goes to IDLE; wait counter, instrCount and fault clear to 0.
  - All outputs read 0 while reset_n is low.
- Outputs are 0 unless listed for a state. They are Moore-decoded from state, except the FETCH and memory-state strobes, which are gated by memReady, and the BRANCH pcWrite, which is gated by zero.
- IDLE (0):
  - start=1 goes to FETCH. Otherwise stay.
- FETCH (1):
  - memReq=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - If memReady: irWrite=1, pcWrite=1, go to DECODE. Otherwise stay.
- DECODE (2):
  - aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut).
  - Dispatch on opcode:
    - 0x00 to RTEXE
    - 0x23 or 0x2B to MEMADR
    - 0x04 to BRANCH
    - 0x08 to ADDIEXE
    - 0x02 or 0x03 to JUMP
    - 0x3F (HALT) to IDLE, retired
    - any other to FAULT
- MEMADR (3):
  - aluSrcA=1, aluSrcB=10, aluOp=00.
  - Go to MEMRD for 0x23, MEMWR for 0x2B.
- MEMRD (4):
  - memReq=1, iOrD=1.
  - If memReady go to MEMWB. Otherwise stay.
- MEMWB (5):
  - regWrite=1, regDst=00, memToReg=01. Then FETCH.
- MEMWR (6):
  - memReq=1, memWE=1, iOrD=1.
  - If memReady go to FETCH. Otherwise stay.
- RTEXE (7):
  - aluSrcA=1, aluSrcB=00, aluOp=10. Then ALUWB.
- ALUWB (8):
  - regWrite=1, regDst=01, memToReg=00. Then FETCH.
- ADDIEXE (9):
  - aluSrcA=1, aluSrcB=10, aluOp=00. Then ADDIWB.
- ADDIWB (10):
  - regWrite=1, regDst=00, memToReg=00. Then FETCH.
- BRANCH (11):
  - aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, pcWrite=zero. Then FETCH.
- JUMP (12):
  - pcSrc=10, pcWrite=1.
  - If opcode is 0x03 (jal): also regWrite=1, regDst=10, memToReg=10.
  - Then FETCH.
- FAULT (13):
  - fault=1, busy=0. Only reset exits; start is ignored.
- Instruction latencies, assuming zero memory wait:
  - FETCH 1 cycle; branch and jump 3 cycles; R-type, addi and sw 4 cycles; lw 5 cycles.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with memReady=0.
  - Clears on memReady or on a state change.
  - When the count reaches MEM_WAIT_MAX with memReady still 0, go to FAULT instead of waiting. memReady on that same cycle wins: the access completes normally.
- instrCount:
  - Increments by 1 on every transition from a final state (MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP) to FETCH, and on DECODE to IDLE for HALT.
  - Wraps modulo 2^CNT_W; no saturation.
  - A branch counts whether taken or not.
- Opcode and zero are sampled only in the states that use them; changes elsewhere are ignored.

Decomposition:
- Package mc_pkg:
  - State enum (4-bit encodings as listed above).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL, OP_HALT.
  - Encodings for pcSrc, regDst, memToReg, aluSrcB and aluOp.
- Sub-module mc_wait_timer: wait counter plus timeout compare, parameterized by MEM_WAIT_MAX.

Test Plan:
- Reset and start:
  - reset_n low mid-FETCH with memReq=1 → all outputs 0 immediately and stateDbg=0.
  - Release reset, then start=1 → FETCH next cycle, busy=1.
- lw with wait states:
  - opcode=0x23, memReady held low 3 cycles in MEMRD.
  - Expect the state sequence FETCH, DECODE, MEMADR, MEMRD×4, MEMWB.
  - Expect regWrite=1 and memToReg=01 for exactly one cycle; instrCount becomes 1.
- beq both ways:
  - zero=1 → pcWrite=1 with pcSrc=01 in BRANCH.
  - zero=0 → pcWrite=0.
  - Both cases: 3 cycles each and instrCount increments twice.
- jal: opcode=0x03 → in JUMP, pcWrite=1, pcSrc=10, regWrite=1, regDst=10, memToReg=10.
- Illegal opcode and HALT:
  - opcode=0x3E → FAULT after DECODE; fault stays 1 despite start pulses.
  - Separately, opcode=0x3F → IDLE, busy=0, instrCount incremented.
- Timeout with MEM_WAIT_MAX=4, memReady=0 in MEMWR:
  - Expect FAULT after 4 wait cycles.
  - Repeat with memReady=1 on the 4th cycle → FETCH, no fault.
